onehot_alu_driver: RTL and testbench
====================================

# onehot_alu_driver

Sequential front-end that drives the combinational one-hot ALU top level. It accepts binary operands and an opcode over a valid/ready request channel, converts each 4-bit operand to a 16-bit one-hot word, and holds those words and the opcode on the ALU inputs for a settle window. It then samples the ALU's one-hot result and converts it back to binary, returning result, overflow and a one-hot validity flag over a valid/ready response channel.

## Interface
- SETTLE_CYCLES, 2, cycles the ALU inputs are held before sampling; legal 1..15.

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_opc  input  3  ALU opcode, passed through unchanged
- req_a  input  4  operand A (binary)
- req_b  input  4  operand B (binary)
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer takes the response
- rsp_result  output  4  binary ALU result
- rsp_overflow  output  1  captured ALU overflow (carry-out)
- rsp_err  output  1  captured one-hot result did not have exactly one bit set
- op_count  output  8  completed response handshakes, wraps
- alu_inp1  output  16  one-hot operand A to ALU
- alu_inp2  output  16  one-hot operand B to ALU
- alu_opc  output  3  opcode to ALU
- alu_out  input  16  one-hot ALU result
- alu_overflow  input  1  ALU overflow

## Operation
- FSM states are IDLE, SETTLE and RESP.
- IDLE:
  - req_ready=1, rsp_valid=0.
  - On req_valid&&req_ready: alu_inp1 ← 1<<req_a, alu_inp2 ← 1<<req_b, alu_opc ← req_opc; load settle counter with SETTLE_CYCLES-1; go to SETTLE.
- SETTLE:
  - req_ready=0.
  - Counter decrements each cycle.
  - At counter==0: capture alu_out and alu_overflow into the response registers, then go to RESP.
- RESP:
  - rsp_valid=1; rsp_result, rsp_overflow and rsp_err are held stable.
  - On rsp_ready: op_count+1 (mod 256), go to IDLE.
- alu_inp1, alu_inp2 and alu_opc are registered outputs. They stay stable from the accept edge until the next accept, and are never changed while in SETTLE or RESP.
- Result conversion: rsp_result = index of the highest set bit of alu_out; 0 if alu_out is all zeros.
- req_valid while not in IDLE is ignored; the request is not consumed.

## Timing
- Reset values (asynchronous, immediate on rst):
  - state=IDLE, req_ready=1, rsp_valid=0.
  - rsp_result=0, rsp_overflow=0, rsp_err=0, op_count=0.
  - alu_inp1=16'h0001, alu_inp2=16'h0001, alu_opc=3'b000.
- Accept at edge E0. alu_* update at E0. Capture occurs at edge E0+SETTLE_CYCLES. rsp_valid is high from that edge.
- Response handshake at edge E1 returns the block to IDLE. The earliest next accept is E1+1, giving minimum issue spacing of SETTLE_CYCLES+2 cycles.
- req_ready and rsp_valid are never both 1.
- Reset asserted in SETTLE or RESP: the in-flight operation is dropped, no response is produced, and op_count does not increment.
- op_count wraps from 255 to 0 with no flag.

## Configuration
- ONEHOT_CHECK_EN defined: rsp_err = (popcount(alu_out) != 1), captured with the result.
- ONEHOT_CHECK_EN undefined: the popcount logic is omitted and rsp_err is tied to 0. Result conversion is unchanged (highest set bit).

## Test plan
- Add with SETTLE_CYCLES=2: a=3, b=5, opc=001 → alu_inp1=16'h0008, alu_inp2=16'h0020 at the accept edge; bench ALU returns 16'h0100 → rsp_valid high 2 edges after accept, rsp_result=8, rsp_overflow=0, rsp_err=0.
- Subtract: a=2, b=5, opc=010 → ALU returns 16'h2000 with overflow=0 → rsp_result=13, rsp_overflow=0; op_count increments by 1 on the handshake.
- Backpressure: hold rsp_ready=0 for 5 cycles while toggling req_valid and new operands → rsp_* stable, req_ready=0, alu_* unchanged, no second accept; release rsp_ready → IDLE next cycle.
- Error detection with ONEHOT_CHECK_EN defined:
  - Force alu_out=16'h0000 → rsp_err=1, rsp_result=0.
  - Force alu_out=16'h0030 → rsp_err=1, rsp_result=5.
  - Same stimulus with the macro undefined → rsp_err=0.
- Assert rst during SETTLE → all outputs at reset values immediately, no rsp_valid after release, op_count=0.
- Complete 256 transactions back-to-back → op_count reads 0 after the last handshake.

Source files
------------

// File: rtl/onehot_alu_driver.sv
`default_nettype none
// ============================================================================
// Module   : onehot_alu_driver
// Purpose  : Sequential front-end for a combinational one-hot ALU. Accepts
//            binary operands/opcode over a valid/ready request channel,
//            drives one-hot operands to the ALU for SETTLE_CYCLES cycles,
//            samples the one-hot result, converts it back to binary and
//            returns it over a valid/ready response channel.
// Ports    : clk, rst (async, active-high)
//            req_valid/req_ready/req_opc/req_a/req_b   request channel
//            rsp_valid/rsp_ready/rsp_result/rsp_overflow/rsp_err  response
//            op_count        completed response handshakes (wraps at 256)
//            alu_inp1/alu_inp2/alu_opc  registered one-hot ALU inputs
//            alu_out/alu_overflow       ALU result inputs
// Config   : define ONEHOT_CHECK_EN to flag captured results whose
//            popcount is not exactly one (rsp_err); otherwise rsp_err = 0.
// Revision : 1.0 - initial release
// ============================================================================
module onehot_alu_driver #(
    parameter int SETTLE_CYCLES = 2     // legal 1..15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_opc,
    input  logic [3:0]  req_a,
    input  logic [3:0]  req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [3:0]  rsp_result,
    output logic        rsp_overflow,
    output logic        rsp_err,
    output logic [7:0]  op_count,
    output logic [15:0] alu_inp1,
    output logic [15:0] alu_inp2,
    output logic [2:0]  alu_opc,
    input  logic [15:0] alu_out,
    input  logic        alu_overflow
);

    localparam logic [3:0] c_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] alu_inp1_q, alu_inp1_d;
    logic [15:0] alu_inp2_q, alu_inp2_d;
    logic [2:0]  alu_opc_q, alu_opc_d;
    logic [3:0]  result_q, result_d;
    logic        overflow_q, overflow_d;
    logic        err_q, err_d;
    logic [7:0]  op_count_q, op_count_d;

    logic [3:0]  w_enc;
    logic        w_err;

    // Highest-set-bit encoder: later (higher) indices override lower ones,
    // so an all-zero word yields 0.
    always_comb begin
        w_enc = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (alu_out[i]) begin
                w_enc = 4'(i);
            end
        end
    end

`ifdef ONEHOT_CHECK_EN
    logic [4:0] w_pop;
    always_comb begin
        w_pop = 5'd0;
        for (int i = 0; i < 16; i++) begin
            w_pop = w_pop + {4'd0, alu_out[i]};
        end
        w_err = (w_pop != 5'd1);
    end
`else
    assign w_err = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        alu_inp1_d = alu_inp1_q;
        alu_inp2_d = alu_inp2_q;
        alu_opc_d  = alu_opc_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        err_d      = err_q;
        op_count_d = op_count_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    alu_inp1_d = 16'd1 << req_a;
                    alu_inp2_d = 16'd1 << req_b;
                    alu_opc_d  = req_opc;
                    cnt_d      = c_SETTLE_LOAD;
                    state_d    = S_SETTLE;
                end
            end
            S_SETTLE: begin
                // Counter starts at SETTLE_CYCLES-1, so capture lands exactly
                // SETTLE_CYCLES edges after the accept edge.
                if (cnt_q == 4'd0) begin
                    result_d   = w_enc;
                    overflow_d = alu_overflow;
                    err_d      = w_err;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    op_count_d = op_count_q + 8'd1;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            alu_inp1_q <= 16'h0001;
            alu_inp2_q <= 16'h0001;
            alu_opc_q  <= 3'b000;
            result_q   <= 4'd0;
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
            op_count_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            alu_inp1_q <= alu_inp1_d;
            alu_inp2_q <= alu_inp2_d;
            alu_opc_q  <= alu_opc_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            err_q      <= err_d;
            op_count_q <= op_count_d;
        end
    end

    // Handshake flags decode directly from state, so they can never both be high.
    assign req_ready    = (state_q == S_IDLE);
    assign rsp_valid    = (state_q == S_RESP);
    assign rsp_result   = result_q;
    assign rsp_overflow = overflow_q;
    assign rsp_err      = err_q;
    assign op_count     = op_count_q;
    assign alu_inp1     = alu_inp1_q;
    assign alu_inp2     = alu_inp2_q;
    assign alu_opc      = alu_opc_q;

endmodule
`default_nettype wire

// File: tb/tb_onehot_alu_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_onehot_alu_driver
// Purpose  : Self-checking bench for onehot_alu_driver: directed vector table,
//            reset-in-flight sequence and randomized back-to-back traffic
//            checked against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_onehot_alu_driver;

    localparam int S = 2;

`ifdef ONEHOT_CHECK_EN
    localparam bit c_ERR_EN = 1'b1;
`else
    localparam bit c_ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_opc = 3'd0;
    logic [3:0]  req_a = 4'd0;
    logic [3:0]  req_b = 4'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [3:0]  rsp_result;
    logic        rsp_overflow;
    logic        rsp_err;
    logic [7:0]  op_count;
    logic [15:0] alu_inp1;
    logic [15:0] alu_inp2;
    logic [2:0]  alu_opc;
    logic [15:0] alu_out = 16'd0;
    logic        alu_overflow = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int exp_count = 0;

    onehot_alu_driver #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_opc(req_opc),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_overflow(rsp_overflow), .rsp_err(rsp_err), .op_count(op_count),
        .alu_inp1(alu_inp1), .alu_inp2(alu_inp2), .alu_opc(alu_opc),
        .alu_out(alu_out), .alu_overflow(alu_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: highest set bit as floor(log2(v)), 0 for v==0.
    function automatic logic [3:0] m_result(input logic [15:0] v);
        int x;
        x = int'(v);
        if (x == 0) return 4'd0;
        return 4'($clog2(x + 1) - 1);
    endfunction

    function automatic logic m_err(input logic [15:0] v);
        return c_ERR_EN && ($countones(v) != 1);
    endfunction

    // Request and response must never be offered together.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("ready_valid_exclusive", {31'd0, req_ready & rsp_valid}, 32'd0);
        end
    end

    task automatic run_txn(input logic [3:0] a, input logic [3:0] b, input logic [2:0] opc,
                           input logic [15:0] av, input logic ov,
                           input logic [3:0] er, input logic eo, input logic ee,
                           input int stall);
        int e1;
        int e2;
        e1 = 1 << a;
        e2 = 1 << b;
        chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_a = a; req_b = b; req_opc = opc;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0; req_a = 4'($urandom); req_b = 4'($urandom); req_opc = 3'($urandom);
        chk("alu_inp1_onehot", {16'd0, alu_inp1}, e1);
        chk("alu_inp2_onehot", {16'd0, alu_inp2}, e2);
        chk("alu_opc_pass", {29'd0, alu_opc}, {29'd0, opc});
        chk("settle_req_ready", {31'd0, req_ready}, 32'd0);
        alu_out = av; alu_overflow = ov;
        for (int k = 1; k <= S; k++) begin
            @(posedge clk); @(negedge clk);
            chk("rsp_valid_latency", {31'd0, rsp_valid}, (k == S) ? 32'd1 : 32'd0);
        end
        // ALU output moves after capture; response must not follow it.
        alu_out = 16'($urandom); alu_overflow = 1'($urandom);
        chk("rsp_result", {28'd0, rsp_result}, {28'd0, er});
        chk("rsp_overflow", {31'd0, rsp_overflow}, {31'd0, eo});
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, ee});
        for (int k = 0; k < stall; k++) begin
            req_valid = 1'($urandom); req_a = 4'($urandom); req_b = 4'($urandom);
            req_opc = 3'($urandom); rsp_ready = 1'b0;
            @(posedge clk); @(negedge clk);
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
            chk("bp_rsp_result", {28'd0, rsp_result}, {28'd0, er});
            chk("bp_alu_inp1", {16'd0, alu_inp1}, e1);
            chk("bp_alu_inp2", {16'd0, alu_inp2}, e2);
            chk("bp_alu_opc", {29'd0, alu_opc}, {29'd0, opc});
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        rsp_ready = 1'b0;
        exp_count = (exp_count + 1) % 256;
        chk("post_hs_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("post_hs_req_ready", {31'd0, req_ready}, 32'd1);
        chk("op_count", {24'd0, op_count}, exp_count);
    endtask

    typedef struct {
        logic [3:0]  a;
        logic [3:0]  b;
        logic [2:0]  opc;
        logic [15:0] av;
        logic        ov;
        logic [3:0]  er;
        logic        eo;
        logic        ee;
        int          stall;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{a:4'd3,  b:4'd5,  opc:3'b001, av:16'h0100, ov:1'b0, er:4'd8,  eo:1'b0, ee:1'b0,     stall:5};
        vecs[1] = '{a:4'd2,  b:4'd5,  opc:3'b010, av:16'h2000, ov:1'b0, er:4'd13, eo:1'b0, ee:1'b0,     stall:0};
        vecs[2] = '{a:4'd0,  b:4'd0,  opc:3'b011, av:16'h0000, ov:1'b0, er:4'd0,  eo:1'b0, ee:c_ERR_EN, stall:1};
        vecs[3] = '{a:4'd1,  b:4'd1,  opc:3'b100, av:16'h0030, ov:1'b1, er:4'd5,  eo:1'b1, ee:c_ERR_EN, stall:0};
        vecs[4] = '{a:4'd15, b:4'd15, opc:3'b111, av:16'h8000, ov:1'b1, er:4'd15, eo:1'b1, ee:1'b0,     stall:2};

        // Reset state
        @(posedge clk); #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_op_count", {24'd0, op_count}, 32'd0);
        chk("rst_alu_inp1", {16'd0, alu_inp1}, 32'h0001);
        chk("rst_alu_inp2", {16'd0, alu_inp2}, 32'h0001);
        chk("rst_alu_opc", {29'd0, alu_opc}, 32'd0);
        chk("rst_rsp_result", {28'd0, rsp_result}, 32'd0);
        @(negedge clk); rst = 1'b0;

        // Directed table
        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i].a, vecs[i].b, vecs[i].opc, vecs[i].av, vecs[i].ov,
                    vecs[i].er, vecs[i].eo, vecs[i].ee, vecs[i].stall);
        end

        // Reset while in SETTLE drops the operation
        req_valid = 1'b1; req_a = 4'd7; req_b = 4'd9; req_opc = 3'd3;
        alu_out = 16'h4000; alu_overflow = 1'b1;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        chk("pre_rst_in_settle", {31'd0, req_ready}, 32'd0);
        rst = 1'b1; #1;
        chk("arst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("arst_op_count", {24'd0, op_count}, 32'd0);
        chk("arst_alu_inp1", {16'd0, alu_inp1}, 32'h0001);
        chk("arst_alu_inp2", {16'd0, alu_inp2}, 32'h0001);
        chk("arst_alu_opc", {29'd0, alu_opc}, 32'd0);
        chk("arst_rsp_result", {28'd0, rsp_result}, 32'd0);
        chk("arst_rsp_overflow", {31'd0, rsp_overflow}, 32'd0);
        chk("arst_rsp_err", {31'd0, rsp_err}, 32'd0);
        @(negedge clk); rst = 1'b0;
        exp_count = 0;
        for (int k = 0; k < S + 3; k++) begin
            @(posedge clk); @(negedge clk);
            chk("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end

        // 256 randomized back-to-back transactions: op_count must wrap to 0
        for (int i = 0; i < 256; i++) begin
            logic [3:0]  ra;
            logic [3:0]  rb;
            logic [2:0]  ro;
            logic [15:0] rv;
            logic        rov;
            ra = 4'($urandom); rb = 4'($urandom); ro = 3'($urandom); rov = 1'($urandom);
            if ($urandom_range(0, 3) != 0) rv = 16'd1 << 4'($urandom);
            else if ($urandom_range(0, 3) == 0) rv = 16'h0000;
            else rv = 16'($urandom);
            run_txn(ra, rb, ro, rv, rov, m_result(rv), rov, m_err(rv), 0);
        end
        chk("op_count_wrap", {24'd0, op_count}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
